// File: rtl/config_fifo_responder.sv
// Config bus responder: buffers initiator writes in a FIFO and returns them, oldest first, on reads.
// Pops land on read_data one cycle after the r_en edge; dropped writes and refused reads are reported as sticky flags.
module config_fifo_responder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r_en,
    input  logic             w_en,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] read_data,
    output logic             read_valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_c;
    logic             pop_c;

    // Occupancy decode; pointer equality alone is ambiguous, so count is the reference
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == CW'(0));

    // A full FIFO still takes a write when a pop frees a slot in the same cycle
    assign push_c = w_en && (!full || r_en);
    assign pop_c  = r_en && !empty;

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            read_data  <= '0;
            read_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            read_valid <= pop_c;
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                read_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (w_en && full && !r_en) begin
                overflow <= 1'b1;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_config_fifo_responder.sv
// Directed self-checking bench for config_fifo_responder with hand-computed expectations.
module tb_config_fifo_responder;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             r_en;
    logic             w_en;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic             read_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    config_fifo_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .r_en       (r_en),
        .w_en       (w_en),
        .write_data (write_data),
        .read_data  (read_data),
        .read_valid (read_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        w_en = 1'b1;
        write_data = d;
        tick();
        w_en = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [WIDTH-1:0] d);
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check({tag, "_valid"}, 32'(read_valid), 32'd1);
        check({tag, "_data"}, 32'(read_data), 32'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        r_en = 1'b0;
        w_en = 1'b0;
        write_data = '0;
        #3;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_valid", 32'(read_valid), 32'd0);
        check("rst_data", 32'(read_data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // fill to full
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        check("fill_count", 32'(count), 32'd4);
        check("fill_full", 32'(full), 32'd1);
        check("fill_ovf", 32'(overflow), 32'd0);

        // drain in order
        pop_expect("drain0", 8'h11);
        pop_expect("drain1", 8'h22);
        pop_expect("drain2", 8'h33);
        pop_expect("drain3", 8'h44);
        check("drain_count", 32'(count), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_unf", 32'(underflow), 32'd0);
        tick();
        check("idle_valid", 32'(read_valid), 32'd0);
        check("idle_hold", 32'(read_data), 32'h44);

        // simultaneous read/write when full
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        r_en = 1'b1;
        w_en = 1'b1;
        write_data = 8'h55;
        tick();
        r_en = 1'b0;
        w_en = 1'b0;
        check("rw_full_valid", 32'(read_valid), 32'd1);
        check("rw_full_data", 32'(read_data), 32'hA0);
        check("rw_full_count", 32'(count), 32'd4);
        check("rw_full_ovf", 32'(overflow), 32'd0);
        pop_expect("rwd0", 8'hA1);
        pop_expect("rwd1", 8'hA2);
        pop_expect("rwd2", 8'hA3);
        pop_expect("rwd3", 8'h55);
        check("rwd_empty", 32'(empty), 32'd1);

        // simultaneous read/write when empty: push only, no bypass
        r_en = 1'b1;
        w_en = 1'b1;
        write_data = 8'h7E;
        tick();
        r_en = 1'b0;
        w_en = 1'b0;
        check("rw_empty_valid", 32'(read_valid), 32'd0);
        check("rw_empty_unf", 32'(underflow), 32'd1);
        check("rw_empty_count", 32'(count), 32'd1);
        check("rw_empty_hold", 32'(read_data), 32'h55);
        pop_expect("rw_empty_rd", 8'h7E);
        check("rw_empty_count2", 32'(count), 32'd0);

        // overflow drops the write
        push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
        push(8'h99);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        pop_expect("ovf0", 8'hB0);
        pop_expect("ovf1", 8'hB1);
        pop_expect("ovf2", 8'hB2);
        pop_expect("ovf3", 8'hB3);
        check("ovf_empty", 32'(empty), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // reset mid-operation with a read_valid pulse in flight
        push(8'hC1); push(8'hC2); push(8'hC3);
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check("mid_valid_pre", 32'(read_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_count", 32'(count), 32'd0);
        check("mid_valid", 32'(read_valid), 32'd0);
        check("mid_data", 32'(read_data), 32'd0);
        check("mid_empty", 32'(empty), 32'd1);
        check("mid_ovf", 32'(overflow), 32'd0);
        check("mid_unf", 32'(underflow), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("post_ovf", 32'(overflow), 32'd0);
        check("post_unf", 32'(underflow), 32'd0);
        check("post_count", 32'(count), 32'd0);
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check("post_rd_valid", 32'(read_valid), 32'd0);
        check("post_rd_unf", 32'(underflow), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
